// File: rtl/kypd_pkg.sv
`default_nettype none
// ============================================================================
// Module : kypd_pkg
// Brief  : Shared types and the keypad code map for the Pmod KYPD scanner.
// Rev    : 1.0  initial release
// ============================================================================
package kypd_pkg;

  // Classification of one assembled keypad frame
  typedef enum logic [1:0] {
    KC_NONE   = 2'd0,
    KC_SINGLE = 2'd1,
    KC_MULTI  = 2'd2
  } key_class_e;

  // Column scan states, one per driven column
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } scan_state_e;

  // Hex legend printed on the KYPD, indexed by (row, col)
  function automatic logic [3:0] kypd_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] c;
    c = 4'h0;
    case ({row, col})
      4'h0: c = 4'h1;
      4'h1: c = 4'h2;
      4'h2: c = 4'h3;
      4'h3: c = 4'hA;
      4'h4: c = 4'h4;
      4'h5: c = 4'h5;
      4'h6: c = 4'h6;
      4'h7: c = 4'hB;
      4'h8: c = 4'h7;
      4'h9: c = 4'h8;
      4'hA: c = 4'h9;
      4'hB: c = 4'hC;
      4'hC: c = 4'h0;
      4'hD: c = 4'hF;
      4'hE: c = 4'hE;
      4'hF: c = 4'hD;
      default: c = 4'h0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kypd_frame_debounce.sv
`default_nettype none
// ============================================================================
// Module : kypd_frame_debounce
// Brief  : Frame-level debouncer; commits a keypad state after N identical
//          frames and generates the key event outputs.
// Rev    : 1.0  initial release
// ============================================================================
module kypd_frame_debounce
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_stb_i,
  input  key_class_e class_i,
  input  logic [3:0] code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic       multi_key_o
);

  localparam logic [3:0] C_DF = 4'(DEBOUNCE_FRAMES);

  key_class_e cand_class_q, cand_class_d;
  logic [3:0] cand_code_q, cand_code_d;
  logic [3:0] cnt_q, cnt_d;
  key_class_e comm_class_q, comm_class_d;
  logic [3:0] comm_code_q, comm_code_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic       multi_q, multi_d;
  logic       match_w;
  logic       commit_w;

  // Candidate tracking, commit decision and output update per frame.
  // Non-single classes always carry code 0, so comparing code is safe.
  always_comb begin
    cand_class_d = cand_class_q;
    cand_code_d  = cand_code_q;
    cnt_d        = cnt_q;
    comm_class_d = comm_class_q;
    comm_code_d  = comm_code_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    key_held_d   = key_held_q;
    multi_d      = multi_q;
    match_w      = (class_i == cand_class_q) && (code_i == cand_code_q);
    commit_w     = 1'b0;
    if (frame_stb_i) begin
      if (match_w) begin
        cnt_d = (cnt_q >= C_DF) ? C_DF : cnt_q + 4'd1;
      end else begin
        cand_class_d = class_i;
        cand_code_d  = code_i;
        cnt_d        = 4'd1;
      end
      commit_w = (cnt_d == C_DF) &&
                 ((cand_class_d != comm_class_q) || (cand_code_d != comm_code_q));
    end
    if (commit_w) begin
      comm_class_d = cand_class_d;
      comm_code_d  = cand_code_d;
      case (cand_class_d)
        KC_SINGLE: begin
          key_code_d  = cand_code_d;
          key_held_d  = 1'b1;
          multi_d     = 1'b0;
          key_valid_d = 1'b1;
        end
        KC_MULTI: begin
          key_held_d = 1'b0;
          multi_d    = 1'b1;
        end
        default: begin
          key_held_d = 1'b0;
          multi_d    = 1'b0;
        end
      endcase
    end
  end

  // Debounce and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_class_q <= KC_NONE;
      cand_code_q  <= 4'h0;
      cnt_q        <= 4'd0;
      comm_class_q <= KC_NONE;
      comm_code_q  <= 4'h0;
      key_code_q   <= 4'h0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      cand_class_q <= cand_class_d;
      cand_code_q  <= cand_code_d;
      cnt_q        <= cnt_d;
      comm_class_q <= comm_class_d;
      comm_code_q  <= comm_code_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      multi_q      <= multi_d;
    end
  end

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;
  assign multi_key_o = multi_q;

endmodule
`default_nettype wire

// File: rtl/kypd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : kypd_scan_ctrl
// Brief  : Column-strobing scanner for the 4x4 Pmod KYPD with frame assembly,
//          classification and debounced one-cycle key events.
// Rev    : 1.0  initial release
// ============================================================================
module kypd_scan_ctrl
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int            C_CW        = $clog2(SCAN_DIV);
  localparam logic [C_CW-1:0] C_DWELL_MAX = C_CW'(SCAN_DIV - 1);

  scan_state_e     state_q, state_d;
  logic [C_CW-1:0] dwell_q;
  logic [3:0]      row_meta_q, row_sync_q;
  logic [15:0]     frame_q;
  logic            frame_stb_q;
  logic            dwell_end_w;
  logic [1:0]      n_set_w;
  logic [3:0]      idx_w;
  key_class_e      class_w;
  logic [3:0]      code_w;

  assign dwell_end_w = (dwell_q == C_DWELL_MAX);

  // Two-flop synchronizer on the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COL0;
    else        state_q <= state_d;
  end

  // Scan FSM next state: advance one column at the end of each dwell
  always_comb begin
    state_d = state_q;
    if (dwell_end_w) begin
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = COL0;
      endcase
    end
  end

  // Scan FSM outputs: drive exactly one column low
  always_comb begin
    col_n = 4'b1110;
    case (state_q)
      COL1:    col_n = 4'b1101;
      COL2:    col_n = 4'b1011;
      COL3:    col_n = 4'b0111;
      default: col_n = 4'b1110;
    endcase
  end

  // Dwell counter, frame latch and end-of-frame strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q     <= '0;
      frame_q     <= 16'h0000;
      frame_stb_q <= 1'b0;
    end else begin
      frame_stb_q <= dwell_end_w && (state_q == COL3);
      if (dwell_end_w) begin
        dwell_q                    <= '0;
        frame_q[4*state_q +: 4]    <= ~row_sync_q;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  // Frame classification; popcount saturates at two since MULTI needs no more
  always_comb begin
    n_set_w = 2'd0;
    idx_w   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        if (n_set_w == 2'd0) idx_w = 4'(i);
        if (n_set_w != 2'd2) n_set_w = n_set_w + 2'd1;
      end
    end
    case (n_set_w)
      2'd0:    class_w = KC_NONE;
      2'd1:    class_w = KC_SINGLE;
      default: class_w = KC_MULTI;
    endcase
    // frame bit 4*col+row, so idx[1:0] is the row and idx[3:2] the column
    code_w = (class_w == KC_SINGLE) ? kypd_code(idx_w[1:0], idx_w[3:2]) : 4'h0;
  end

  kypd_frame_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_stb_i (frame_stb_q),
    .class_i     (class_w),
    .code_i      (code_w),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_held_o  (key_held),
    .multi_key_o (multi_key)
  );

endmodule
`default_nettype wire

// File: tb/tb_kypd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_kypd_scan_ctrl
// Brief  : Directed self-checking bench for kypd_scan_ctrl with a keypad
//          matrix model (SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16-cycle frame).
// Rev    : 1.0  initial release
// ============================================================================
module tb_kypd_scan_ctrl;

  localparam int C_SCAN_DIV = 4;
  localparam int C_DF       = 3;
  localparam int C_FRAME    = 4 * C_SCAN_DIV;
  localparam int C_LAT_MAX  = C_DF * C_FRAME + 4;

  // Keypad matrix bit index is 4*col + row
  localparam logic [15:0] K_1 = 16'h0001;  // row0 col0
  localparam logic [15:0] K_0 = 16'h0008;  // row3 col0
  localparam logic [15:0] K_5 = 16'h0020;  // row1 col1
  localparam logic [15:0] K_9 = 16'h0400;  // row2 col2
  localparam logic [15:0] K_A = 16'h1000;  // row0 col3
  localparam logic [15:0] K_D = 16'h8000;  // row3 col3

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] pressed;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses = 0;

  kypd_scan_ctrl #(
    .SCAN_DIV        (C_SCAN_DIV),
    .DEBOUNCE_FRAMES (C_DF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row to its driven-low column
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && pressed[4*c+r]) row_n[r] = 1'b0;
  end

  // Count every cycle key_valid is high
  always @(negedge clk) if (rst_n && key_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Return at the negedge of the first cycle of a new frame (COL0, dwell 0)
  task automatic wait_frame_start();
    logic [3:0] prev;
    bit         ok;
    ok   = 1'b0;
    prev = col_n;
    for (int i = 0; i < 3 * C_FRAME && !ok; i++) begin
      @(negedge clk);
      if (col_n == 4'b1110 && prev == 4'b0111) ok = 1'b1;
      prev = col_n;
    end
    if (!ok) chk("frame_align", 0, 1);
  endtask

  // Wait up to max cycles for key_valid; at = cycles waited, 0 if none
  task automatic wait_pulse(input int max, output int at);
    at = 0;
    for (int i = 1; i <= max && at == 0; i++) begin
      @(negedge clk);
      if (key_valid) at = i;
    end
  endtask

  initial begin
    int         p0;
    int         at;
    logic [3:0] exp_col;

    rst_n   = 1'b0;
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_multi_key", multi_key, 0);

    // Idle: column sequence, each column held SCAN_DIV cycles
    rst_n = 1'b1;
    for (int j = 0; j < C_FRAME; j++) begin
      exp_col = ~(4'b0001 << (j / C_SCAN_DIV));
      chk($sformatf("idle_col_n_%0d", j), col_n, exp_col);
      @(negedge clk);
    end
    repeat (9 * C_FRAME) @(negedge clk);
    chk("idle_no_pulse", pulses, 0);
    chk("idle_key_held", key_held, 0);
    chk("idle_key_code", key_code, 0);

    // Single press '5' for 6 frames, then release for 3 frames
    wait_frame_start();
    p0      = pulses;
    pressed = K_5;
    wait_pulse(C_LAT_MAX, at);
    chk("k5_pulse_in_time", (at != 0), 1);
    chk("k5_key_code", key_code, 4'h5);
    @(negedge clk);
    chk("k5_key_held", key_held, 1);
    chk("k5_pulse_one_cycle", key_valid, 0);
    repeat (6 * C_FRAME - at - 1) @(negedge clk);
    chk("k5_one_pulse", pulses - p0, 1);
    chk("k5_still_held", key_held, 1);
    pressed = 16'h0;
    repeat (3 * C_FRAME + 4) @(negedge clk);
    chk("k5_release_held", key_held, 0);
    chk("k5_release_code", key_code, 4'h5);
    chk("k5_release_pulses", pulses - p0, 1);

    // Bounce: '9' present on alternate frames only
    wait_frame_start();
    p0 = pulses;
    for (int f = 0; f < 12; f++) begin
      pressed = (f % 2 == 0) ? K_9 : 16'h0;
      repeat (C_FRAME) @(negedge clk);
    end
    pressed = 16'h0;
    chk("bounce_no_pulse", pulses - p0, 0);
    chk("bounce_key_held", key_held, 0);

    // Multi-key '1'+'D' for 4 frames
    wait_frame_start();
    p0      = pulses;
    pressed = K_1 | K_D;
    repeat (4 * C_FRAME) @(negedge clk);
    chk("multi_multi_key", multi_key, 1);
    chk("multi_key_held", key_held, 0);
    chk("multi_no_pulse", pulses - p0, 0);
    chk("multi_code_kept", key_code, 4'h5);

    // Release 'D', leaving '1'
    pressed = K_1;
    wait_pulse(C_LAT_MAX, at);
    chk("k1_pulse", (at != 0), 1);
    chk("k1_key_code", key_code, 4'h1);
    chk("k1_multi_clear", multi_key, 0);
    chk("k1_key_held", key_held, 1);

    // Direct switch '1' -> 'A'
    wait_frame_start();
    pressed = K_A;
    wait_pulse(C_LAT_MAX, at);
    chk("kA_pulse", (at != 0), 1);
    chk("kA_key_code", key_code, 4'hA);

    // Commit '0', then reset asynchronously while it is held
    wait_frame_start();
    pressed = K_0;
    wait_pulse(C_LAT_MAX, at);
    chk("k0_pulse", (at != 0), 1);
    chk("k0_key_code", key_code, 4'h0);
    repeat (7) @(negedge clk);
    chk("k0_pre_rst_held", key_held, 1);
    chk("k0_pre_rst_col_n", (col_n != 4'b1110), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_key_held", key_held, 0);
    chk("midrst_col_n", col_n, 4'b1110);
    chk("midrst_key_valid", key_valid, 0);
    #9 rst_n = 1'b1;
    p0 = pulses;
    wait_pulse(C_LAT_MAX + C_FRAME, at);
    chk("midrst_refire_window", (at >= C_DF * C_FRAME) && (at <= C_LAT_MAX), 1);
    chk("midrst_refire_code", key_code, 4'h0);
    repeat (C_FRAME) @(negedge clk);
    chk("midrst_one_pulse", pulses - p0, 1);
    chk("midrst_key_held", key_held, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
